geo_cmd_streamer: RTL
=====================

# geo_cmd_streamer

Command-list transmitter for the geometry processor. It fetches a list of 16-bit geometry commands from GPU RAM through a data_mux_geo-style read port and streams them into the geometry processor's `fifo_cmd_ready`/`fifo_cmd_in` input, honouring `fifo_cmd_busy` back-pressure. The Z80 can then launch a whole drawing list with one start strobe instead of writing every command word itself.

## Interface
Parameters:
- `PREFETCH_DEPTH`, 4: words of read-ahead buffer; power of two, 2..16.
- `ADDR_W`, 20: RAM address width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle launch pulse; sampled only in IDLE.
- `abort`  in  1  one-cycle stop pulse.
- `list_base`  in  ADDR_W  byte address of the first command word; bit 0 is ignored (forced 0).
- `list_len`  in  16  number of 16-bit words to send.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `words_sent`  out  16  words strobed out since the last start.
- `rd_req`  out  1  read request to the RAM mux.
- `ram_addr`  out  ADDR_W  read address.
- `ram_mux_busy`  in  1  mux cannot accept a request.
- `rd_data_rdy`  in  1  `rd_data_in` is valid, one per accepted request, in order.
- `rd_data_in`  in  16  read data.
- `cmd_busy`  in  1  from the geometry processor's `fifo_cmd_busy`.
- `cmd_strobe`  out  1  drives the geometry processor's `fifo_cmd_ready`.
- `cmd_data`  out  16  drives the geometry processor's `fifo_cmd_in`.

## Operation
- **States:** IDLE, FETCH, FLUSH.
- **IDLE:**
  - `start` with `list_len`≠0: latch base and length, clear `words_sent`, go to FETCH.
  - `start` with `list_len`=0: pulse `done` on the next cycle and stay in IDLE.
- **Read issue (FETCH):**
  - Issue a read while `issued < list_len` and `fill + outstanding < PREFETCH_DEPTH`.
  - `rd_req` is high only in cycles where `ram_mux_busy` is low. Each cycle with `rd_req` high is one accepted read.
  - After each accepted read, `ram_addr` advances by 2 and `outstanding` increments.
- **Read return:** `rd_data_rdy` writes `rd_data_in` into the prefetch FIFO and decrements `outstanding`. `rd_data_rdy` while `outstanding`=0 is ignored.
- **Emit:**
  - When FIFO fill > 0 and `cmd_busy` is low, pop one word and assert `cmd_strobe` for one cycle with `cmd_data`. At most one word per cycle.
  - `words_sent` increments with each strobe.
- **Simultaneous events:** a return and a pop in the same cycle leave fill unchanged. An issue and a return in the same cycle leave `outstanding` unchanged.
- **Completion:** `words_sent` = `list_len` → pulse `done`, go to IDLE.
- **Abort (any non-IDLE state):**
  - Stop issuing reads, clear the FIFO, suppress strobes, go to FLUSH.
  - FLUSH discards returning reads until `outstanding`=0, then goes to IDLE. No `done` pulse.
- **Address arithmetic:** addition is modulo 2^ADDR_W; wrap-around past the top of RAM is permitted.
- **Start while busy:** ignored.

## Timing
- **Reset values** (asserted asynchronously): `busy`, `done`, `rd_req`, `cmd_strobe` = 0; `ram_addr`, `cmd_data`, `words_sent` = 0; FIFO empty; `outstanding` = 0; state IDLE.
- **Reset mid-list:** state is lost and no `done` is pulsed. In-flight read data arriving after reset release is ignored because `outstanding`=0.
- **Start:** `start` in cycle N gives `busy` high and the first `rd_req` in cycle N+1, provided `ram_mux_busy` is low.
- **Data latency:** `rd_data_rdy` in cycle M gives `cmd_strobe` no earlier than M+1 (FIFO is registered).
- **Back-pressure:** `cmd_busy` is sampled in the strobe cycle. With `cmd_busy` high there is no strobe, and `cmd_data` holds its last value. The geometry processor's FIFO margin covers its own latency; this block adds no extra words after `cmd_busy` rises.
- **Done:** `done` is high the cycle after the final strobe. `busy` falls in that same cycle.
- **Throughput:** one word per clock sustained when RAM returns one word per clock and `PREFETCH_DEPTH` ≥ the round-trip latency.

## Configuration
- **`GEO_STREAM_REPEAT_EN` defined:**
  - On completion, no `done` pulse. `ram_addr` reloads `list_base`, `words_sent` clears, and streaming continues seamlessly until `abort`.
  - Prefetch may run ahead across the list boundary.
- **`GEO_STREAM_REPEAT_EN` undefined:** single pass as described above. The repeat logic is absent.

## Test plan
- **Basic list:** `list_base`=0x01000, `list_len`=3, RAM latency 2, `cmd_busy`=0.
  - Reads at 0x01000, 0x01002, 0x01004.
  - Three strobes carrying the RAM words in order.
  - `done` one cycle after the third strobe; `words_sent`=3.
- **Back-pressure:** `list_len`=8, `cmd_busy` high for 10 cycles after the 2nd strobe.
  - No strobes while `cmd_busy` is high.
  - Reads stop with fill+outstanding=4.
  - All 8 words delivered in order with none duplicated.
- **Mux stall and wrap:** `ram_mux_busy` toggling every cycle, `list_base`=0xFFFFE, `list_len`=2.
  - `rd_req` only in cycles where `ram_mux_busy` is low.
  - Addresses 0xFFFFE then 0x00000.
- **Zero length and ignored start:**
  - `list_len`=0: `done` in cycle N+1, `rd_req` never asserted.
  - `start` while busy: ignored.
- **Abort:** abort with 3 reads outstanding.
  - No strobe after the abort.
  - FLUSH absorbs 3 `rd_data_rdy` pulses, then `busy` falls.
  - No `done` pulse.
- **Reset and repeat:**
  - `reset` low mid-list: all outputs 0 immediately.
  - With `GEO_STREAM_REPEAT_EN` defined and `list_len`=2, words A,B: strobes A,B,A,B… until `abort`.

Source files
------------

// File: rtl/geo_cmd_streamer.sv
// geo_cmd_streamer: fetches a list of 16-bit geometry commands from GPU RAM and streams
// them into the geometry command FIFO. Define GEO_STREAM_REPEAT_EN to loop the list until abort.
module geo_cmd_streamer #(
   parameter int PREFETCH_DEPTH = 4,
   parameter int ADDR_W         = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] list_base,
   input  logic [15:0]       list_len,
   output logic              busy,
   output logic              done,
   output logic [15:0]       words_sent,
   output logic              rd_req,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic              ram_mux_busy,
   input  logic              rd_data_rdy,
   input  logic [15:0]       rd_data_in,
   input  logic              cmd_busy,
   output logic              cmd_strobe,
   output logic [15:0]       cmd_data
);

   localparam int PTR_W = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(PREFETCH_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
   state_t state_reg, state_next;

`ifdef GEO_STREAM_REPEAT_EN
   logic [ADDR_W-1:0] base_reg;
`endif
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] start_addr;
   logic [15:0]       len_reg, issued_reg, sent_reg;
   logic [CNT_W-1:0]  fill_reg, outst_reg, outst_next;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [15:0]       fifo_mem [PREFETCH_DEPTH];
   logic [15:0]       last_data_reg;
   logic              done_reg;

   logic              issue, ret, push, pop, last_word;
   logic [CNT_W:0]    pending;

   assign start_addr = list_base & ~ADDR_W'(1);
   assign pending    = {1'b0, fill_reg} + {1'b0, outst_reg};
   // Returns with nothing in flight are stale (e.g. from before a reset) and are dropped.
   assign ret        = rd_data_rdy && (outst_reg != '0);
   assign push       = ret && (state_reg == FETCH) && !abort;
   assign issue      = (state_reg == FETCH) && !abort && !ram_mux_busy &&
                       (issued_reg < len_reg) && (pending < DEPTH_C);
   assign pop        = (state_reg == FETCH) && !abort && !cmd_busy && (fill_reg != '0);
   assign last_word  = pop && ((sent_reg + 16'd1) == len_reg);

   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign words_sent = sent_reg;
   assign rd_req     = issue;
   assign ram_addr   = addr_reg;
   assign cmd_strobe = pop;
   assign cmd_data   = pop ? fifo_mem[rd_ptr_reg] : last_data_reg;

   always_comb begin
      outst_next = outst_reg;
      if (issue && !ret)
         outst_next = outst_reg + CNT_W'(1);
      else if (ret && !issue)
         outst_next = outst_reg - CNT_W'(1);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start && (list_len != 16'd0))
               state_next = FETCH;
         end
         FETCH: begin
            if (abort)
               state_next = FLUSH;
`ifndef GEO_STREAM_REPEAT_EN
            else if (last_word)
               state_next = IDLE;
`endif
         end
         FLUSH: begin
            if (outst_next == '0)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= rd_data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
`ifdef GEO_STREAM_REPEAT_EN
         base_reg      <= '0;
`endif
         addr_reg      <= '0;
         len_reg       <= '0;
         issued_reg    <= '0;
         sent_reg      <= '0;
         outst_reg     <= '0;
         fill_reg      <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         last_data_reg <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         outst_reg <= outst_next;
         done_reg  <= 1'b0;
         if (state_reg == IDLE) begin
            if (start) begin
               sent_reg <= '0;
               if (list_len == 16'd0) begin
                  done_reg <= 1'b1;
               end else begin
`ifdef GEO_STREAM_REPEAT_EN
                  base_reg <= start_addr;
`endif
                  addr_reg   <= start_addr;
                  len_reg    <= list_len;
                  issued_reg <= '0;
                  fill_reg   <= '0;
                  wr_ptr_reg <= '0;
                  rd_ptr_reg <= '0;
               end
            end
         end else if (abort && (state_reg == FETCH)) begin
            fill_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (issue) begin
`ifdef GEO_STREAM_REPEAT_EN
               // Prefetch wraps to the list head as soon as the last word is requested.
               if ((issued_reg + 16'd1) == len_reg) begin
                  addr_reg   <= base_reg;
                  issued_reg <= '0;
               end else begin
                  addr_reg   <= addr_reg + ADDR_W'(2);
                  issued_reg <= issued_reg + 16'd1;
               end
`else
               addr_reg   <= addr_reg + ADDR_W'(2);
               issued_reg <= issued_reg + 16'd1;
`endif
            end
            if (push)
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
               rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
               last_data_reg <= fifo_mem[rd_ptr_reg];
`ifdef GEO_STREAM_REPEAT_EN
               sent_reg <= last_word ? 16'd0 : sent_reg + 16'd1;
`else
               sent_reg <= sent_reg + 16'd1;
               done_reg <= last_word;
`endif
            end
            if (push && !pop)
               fill_reg <= fill_reg + CNT_W'(1);
            else if (pop && !push)
               fill_reg <= fill_reg - CNT_W'(1);
         end
      end
   end

endmodule
